bbus_operand_stage: RTL and testbench
=====================================

Name: bbus_operand_stage

Overview:
Parametrised, registered successor to the CPU's B-bus operand multiplexer. It selects the ALU B operand from register-file data, an extended immediate, the synchronised input switches, or the previously issued operand. The chosen value is held in a one-entry output register behind a valid/ready handshake. It sits between decode/register file and the ALU B input.

Parameters:
DATA_W, 8, width of the B bus, bData and inSwitch
IMM_W, 4, width of the immediate field bit_extend; must satisfy 1 <= IMM_W <= DATA_W
SYNC_STAGES, 2, flip-flop stages in the inSwitch synchroniser; must be >= 2

Ports:
in_clk  input  1  system clock; all state updates on the rising edge
in_rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of in_clk
B_selMUX  input  2  source select: 00 bData, 01 extended bit_extend, 10 synchronised inSwitch, 11 last issued operand
ext_sign  input  1  immediate extension mode: 0 zero-extend, 1 sign-extend from bit IMM_W-1
bData  input  DATA_W  register-file operand
bit_extend  input  IMM_W  immediate field
inSwitch  input  DATA_W  asynchronous board switches
sel_valid  input  1  request: capture an operand this cycle
sel_ready  output  1  stage can accept a request
bBusMUX  output  DATA_W  registered B operand
bBus_valid  output  1  bBusMUX holds an unconsumed operand
bBus_ready  input  1  ALU consumes bBusMUX

Behaviour:
- Reset (in_rst_n=0 at an edge):
  - bBusMUX=0, bBus_valid=0, last-operand register=0.
  - All synchroniser stages=0.
  - Reset overrides a simultaneous request; an operand in flight is dropped.
- Synchroniser: inSwitch passes through SYNC_STAGES flops. A stable change becomes selectable exactly SYNC_STAGES edges later.
- Extension is combinational on the inputs:
  - zero-extend: upper DATA_W-IMM_W bits = 0.
  - sign-extend: upper bits = bit_extend[IMM_W-1].
  - IMM_W = DATA_W: value passes through unchanged.
- sel_ready = !bBus_valid || bBus_ready (combinational; no dependence on sel_valid).
- Accept = sel_valid && sel_ready. On accept, at the next edge:
  - bBusMUX <= selected value.
  - bBus_valid <= 1.
  - last-operand register <= selected value.
- Latency: exactly 1 cycle from accept to bBus_valid=1.
- No accept and bBus_ready=1 while valid: bBus_valid <= 0. bBusMUX keeps its value (not cleared).
- Simultaneous consume and accept: bBus_valid stays 1, bBusMUX takes the new value. Full throughput is one operand per cycle.
- Stall (bBus_valid=1, bBus_ready=0):
  - sel_ready=0; bBusMUX and bBus_valid hold.
  - Requests are ignored; the requester must hold sel_valid.
- B_selMUX=11 selects the last-operand register, i.e. the value last accepted; after reset this is 0. Capturing it re-stores the same value.
- Inputs sampled only on accept; input changes while stalled do not affect bBusMUX.
- No combinational path from bData/inSwitch/bit_extend to any output.

Optional Feature:
Macro BBUS_PARITY_EN.
- Defined:
  - Adds output bBus_par (1 bit), the even parity (XOR reduction) of the value captured into bBusMUX.
  - Registered in the same edge as bBusMUX; reset value 0; holds with bBusMUX.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: drive in_rst_n=0 for 2 edges with sel_valid=1 -> bBusMUX=8'h00, bBus_valid=0, sel_ready=1.
- Source sweep with bData=8'hA0, bit_extend=4'hF, ext_sign=0, inSwitch=8'h05 held more than 2 cycles, bBus_ready=1, sel_valid=1, B_selMUX 00,01,10,11 on consecutive cycles -> bBusMUX 8'hA0, 8'h0F, 8'h05, 8'h05 on successive cycles, bBus_valid=1 throughout.
- Extension: bit_extend=4'b1010, ext_sign=1 -> 8'hFA; ext_sign=0 -> 8'h0A; bit_extend=4'b0111, ext_sign=1 -> 8'h07.
- Stall: capture 8'hA0, then bBus_ready=0 for 3 cycles while bData=8'h33 and sel_valid=1 -> bBusMUX stays 8'hA0, sel_ready=0. Release bBus_ready -> next edge bBusMUX=8'h33.
- Synchroniser latency: inSwitch 8'h00 -> 8'h5A at edge N, B_selMUX=10 with an accept every cycle -> captured value is 8'h00 through the accept at edge N+1 and 8'h5A from the accept at edge N+2 on (SYNC_STAGES=2).
- Reset mid-operation and parity: with bBus_valid=1 holding 8'h5A, assert in_rst_n=0 for one edge -> bBus_valid=0, bBusMUX=0, and B_selMUX=11 next returns 8'h00. With BBUS_PARITY_EN, capturing 8'h07 gives bBus_par=1 and 8'h5A gives bBus_par=0.

Source files
------------

// File: rtl/bbus_operand_stage.sv
// Registered B-bus operand selector with a valid/ready output register and an inSwitch synchroniser.
// Optional feature: define BBUS_PARITY_EN to add the registered even-parity output bBus_par.
module bbus_operand_stage #(
  parameter int DATA_W      = 8,
  parameter int IMM_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic [1:0]        B_selMUX,
  input  logic              ext_sign,
  input  logic [DATA_W-1:0] bData,
  input  logic [IMM_W-1:0]  bit_extend,
  input  logic [DATA_W-1:0] inSwitch,
  input  logic              sel_valid,
  output logic              sel_ready,
  output logic [DATA_W-1:0] bBusMUX,
  output logic              bBus_valid,
  input  logic              bBus_ready
`ifdef BBUS_PARITY_EN
  ,
  output logic              bBus_par
`endif
);

  typedef enum logic [1:0] {
    SRC_BDATA  = 2'b00,
    SRC_IMM    = 2'b01,
    SRC_SWITCH = 2'b10,
    SRC_LAST   = 2'b11
  } srcSel_e;

  logic [DATA_W-1:0] syncQ [SYNC_STAGES];
  logic [DATA_W-1:0] extImm;
  logic [DATA_W-1:0] selValue;
  logic [DATA_W-1:0] opQ;
  logic [DATA_W-1:0] lastQ;
  logic              validQ;
  logic              accept;

  // Full-width immediates have no upper bits to fill.
  if (IMM_W == DATA_W) begin : gExtFull
    always_comb extImm = bit_extend;
  end else begin : gExtPart
    always_comb extImm = {{(DATA_W-IMM_W){ext_sign & bit_extend[IMM_W-1]}}, bit_extend};
  end

  always_comb begin
    selValue = bData;
    unique case (srcSel_e'(B_selMUX))
      SRC_BDATA:  selValue = bData;
      SRC_IMM:    selValue = extImm;
      SRC_SWITCH: selValue = syncQ[SYNC_STAGES-1];
      SRC_LAST:   selValue = lastQ;
      default:    selValue = bData;
    endcase
  end

  assign sel_ready  = !validQ || bBus_ready;
  assign accept     = sel_valid && sel_ready;
  assign bBusMUX    = opQ;
  assign bBus_valid = validQ;

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) syncQ[i] <= '0;
    end else begin
      syncQ[0] <= inSwitch;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
    end
  end

  // A consume without a new accept clears valid but leaves the data in place.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      opQ    <= '0;
      lastQ  <= '0;
      validQ <= 1'b0;
    end else if (accept) begin
      opQ    <= selValue;
      lastQ  <= selValue;
      validQ <= 1'b1;
    end else if (bBus_ready) begin
      validQ <= 1'b0;
    end
  end

`ifdef BBUS_PARITY_EN
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      bBus_par <= 1'b0;
    end else if (accept) begin
      bBus_par <= ^selValue;
    end
  end
`endif

endmodule

// File: tb/tb_bbus_operand_stage.sv
// Scoreboard bench for bbus_operand_stage: driver pushes expected operands, negedge monitor compares.
module tb_bbus_operand_stage;

  logic       clk = 1'b1;
  logic       rstN;
  logic [1:0] selMux;
  logic       extSign;
  logic [7:0] bData;
  logic [3:0] bitExt;
  logic [7:0] inSw;
  logic       selValid;
  logic       selReady;
  logic [7:0] bBus;
  logic       bBusValid;
  logic       bBusReady;
`ifdef BBUS_PARITY_EN
  logic       bBusPar;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ [$];
  logic       mValid = 1'b0;

  always #5 clk = ~clk;

  bbus_operand_stage #(.DATA_W(8), .IMM_W(4), .SYNC_STAGES(2)) dut (
    .in_clk    (clk),
    .in_rst_n  (rstN),
    .B_selMUX  (selMux),
    .ext_sign  (extSign),
    .bData     (bData),
    .bit_extend(bitExt),
    .inSwitch  (inSw),
    .sel_valid (selValid),
    .sel_ready (selReady),
    .bBusMUX   (bBus),
    .bBus_valid(bBusValid),
    .bBus_ready(bBusReady)
`ifdef BBUS_PARITY_EN
    ,
    .bBus_par  (bBusPar)
`endif
  );

  // Monitor: every presented operand must match the scoreboard head; pop on consume.
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      checks++;
      if (bBusValid !== mValid) begin
        errors++;
        $display("FAIL valid: got %b want %b at %0t", bBusValid, mValid, $time);
      end
      if (bBusValid === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_operand: got %h want none at %0t", bBus, $time);
        end else begin
          checks++;
          if (bBus !== expQ[0]) begin
            errors++;
            $display("FAIL operand: got %h want %h at %0t", bBus, expQ[0], $time);
          end
`ifdef BBUS_PARITY_EN
          checks++;
          if (bBusPar !== ^expQ[0]) begin
            errors++;
            $display("FAIL parity: got %b want %b at %0t", bBusPar, ^expQ[0], $time);
          end
`endif
          if (bBusReady === 1'b1) void'(expQ.pop_front());
        end
      end
    end
  end

  task automatic step(input logic rst, input logic sv, input logic [1:0] sel,
                      input logic es, input logic [7:0] bd, input logic [3:0] imm,
                      input logic [7:0] sw, input logic rdy, input logic [7:0] expVal);
    logic modelReady;
    rstN = rst; selValid = sv; selMux = sel; extSign = es;
    bData = bd; bitExt = imm; inSw = sw; bBusReady = rdy;
    modelReady = !mValid || rdy;
    @(negedge clk);
    if (rst) begin
      checks++;
      if (selReady !== modelReady) begin
        errors++;
        $display("FAIL sel_ready: got %b want %b at %0t", selReady, modelReady, $time);
      end
    end
    @(posedge clk);
    if (!rst) begin
      mValid = 1'b0;
      expQ.delete();
    end else if (sv && modelReady) begin
      expQ.push_back(expVal);
      mValid = 1'b1;
    end else if (rdy) begin
      mValid = 1'b0;
    end
    #1;
  endtask

  task automatic checkOut(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  initial begin
    // Reset with a pending request: request must be ignored.
    step(0, 1, 2'b00, 0, 8'hA0, 4'hF, 8'h05, 0, 8'h00);
    step(0, 1, 2'b00, 0, 8'hA0, 4'hF, 8'h05, 0, 8'h00);
    rstN = 1'b1; selValid = 1'b0;
    @(negedge clk);
    checkOut("reset_bBusMUX", bBus, 8'h00);
    checkOut("reset_valid", {7'd0, bBusValid}, 8'h00);
    checkOut("reset_sel_ready", {7'd0, selReady}, 8'h01);
    @(posedge clk); #1;

    // Source sweep; inSwitch has been 05 since reset so it is already synchronised.
    step(1, 1, 2'b00, 0, 8'hA0, 4'hF, 8'h05, 1, 8'hA0);
    step(1, 1, 2'b01, 0, 8'hA0, 4'hF, 8'h05, 1, 8'h0F);
    step(1, 1, 2'b10, 0, 8'hA0, 4'hF, 8'h05, 1, 8'h05);
    step(1, 1, 2'b11, 0, 8'hA0, 4'hF, 8'h05, 1, 8'h05);

    // Extension modes.
    step(1, 1, 2'b01, 1, 8'h00, 4'b1010, 8'h05, 1, 8'hFA);
    step(1, 1, 2'b01, 0, 8'h00, 4'b1010, 8'h05, 1, 8'h0A);
    step(1, 1, 2'b01, 1, 8'h00, 4'b0111, 8'h05, 1, 8'h07);
    step(1, 0, 2'b00, 0, 8'h00, 4'h0, 8'h05, 1, 8'h00);

    // Stall: output and sel_ready must hold while ready is low.
    step(1, 1, 2'b00, 0, 8'hA0, 4'h0, 8'h05, 1, 8'hA0);
    step(1, 1, 2'b00, 0, 8'h33, 4'h0, 8'h05, 0, 8'h33);
    step(1, 1, 2'b00, 0, 8'h33, 4'h0, 8'h05, 0, 8'h33);
    step(1, 1, 2'b00, 0, 8'h33, 4'h0, 8'h05, 0, 8'h33);
    step(1, 1, 2'b00, 0, 8'h33, 4'h0, 8'h05, 1, 8'h33);
    step(1, 0, 2'b00, 0, 8'h00, 4'h0, 8'h05, 1, 8'h00);

    // Synchroniser latency: switches settle to 00, then change to 5A at edge N.
    step(1, 0, 2'b10, 0, 8'h00, 4'h0, 8'h00, 1, 8'h00);
    step(1, 0, 2'b10, 0, 8'h00, 4'h0, 8'h00, 1, 8'h00);
    step(1, 0, 2'b10, 0, 8'h00, 4'h0, 8'h00, 1, 8'h00);
    step(1, 1, 2'b10, 0, 8'h00, 4'h0, 8'h5A, 1, 8'h00);
    step(1, 1, 2'b10, 0, 8'h00, 4'h0, 8'h5A, 1, 8'h00);
    step(1, 1, 2'b10, 0, 8'h00, 4'h0, 8'h5A, 1, 8'h5A);
    step(1, 1, 2'b10, 0, 8'h00, 4'h0, 8'h5A, 1, 8'h5A);

    // Hold 5A stalled, then reset mid-operation with a request pending.
    step(1, 1, 2'b00, 0, 8'h5A, 4'h0, 8'h5A, 1, 8'h5A);
    step(1, 0, 2'b00, 0, 8'h00, 4'h0, 8'h5A, 0, 8'h00);
    step(0, 1, 2'b00, 0, 8'h77, 4'h0, 8'h5A, 0, 8'h00);
    rstN = 1'b1; selValid = 1'b0; bBusReady = 1'b1;
    @(negedge clk);
    checkOut("midreset_bBusMUX", bBus, 8'h00);
    checkOut("midreset_valid", {7'd0, bBusValid}, 8'h00);
    @(posedge clk); #1;
    step(1, 1, 2'b11, 0, 8'h99, 4'h0, 8'h5A, 1, 8'h00);

    // Parity-relevant captures (parity checked by the monitor when enabled).
    step(1, 1, 2'b01, 0, 8'h00, 4'b0111, 8'h5A, 1, 8'h07);
    step(1, 1, 2'b00, 0, 8'h5A, 4'h0, 8'h5A, 1, 8'h5A);
    step(1, 0, 2'b00, 0, 8'h00, 4'h0, 8'h5A, 1, 8'h00);
    step(1, 0, 2'b00, 0, 8'h00, 4'h0, 8'h5A, 1, 8'h00);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
